// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: clears, feeds, flushes and reads back an external MAC unit.
// Optional RUN-stall counter (stall_cnt) is built only when MAC_SEQ_CTRL_PERF_CNT_EN is defined.
module mac_seq_ctrl #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       prec_in,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             a_valid,
    input  logic [7:0]       act_in,
    input  logic [7:0]       wgt_in,
    output logic             a_ready,
    output logic [7:0]       mac_act,
    output logic [7:0]       mac_wgt,
    output logic [1:0]       mac_prec,
    output logic             mac_en,
    output logic             mac_rstn,
    input  logic [55:0]      mac_result,
    output logic             res_valid,
    output logic [55:0]      res_data,
    input  logic             res_ready,
`ifdef MAC_SEQ_CTRL_PERF_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             busy,
    output logic             err
);
    localparam int unsigned RES_W  = 56;
    localparam int unsigned PREC_W = 2;
    localparam logic [PREC_W-1:0] PREC_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PREC_W-1:0] prec_q, prec_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic              mac_rstn_q, mac_rstn_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              beat_c;

    // State and job registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            prec_q     <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            mac_rstn_q <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            prec_q     <= prec_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            mac_rstn_q <= mac_rstn_d;
            res_q      <= res_d;
        end
    end

    // Next-state logic; abort overrides every in-flight transition, including the last beat
    always_comb begin
        state_d    = state_q;
        prec_d     = prec_q;
        rem_d      = rem_q;
        err_d      = err_q;
        mac_rstn_d = 1'b1;
        res_d      = res_q;
        beat_c     = (state_q == RUN) && a_valid;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (prec_in == PREC_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        err_d      = 1'b0;
                        prec_d     = prec_in;
                        rem_d      = len;
                        mac_rstn_d = 1'b0;
                        state_d    = CLEAR;
                    end
                end
            end
            CLEAR: state_d = (rem_q == '0) ? FLUSH : RUN;
            RUN: begin
                if (beat_c) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                res_d   = mac_result;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q inside {CLEAR, RUN, FLUSH})) begin
            state_d    = IDLE;
            mac_rstn_d = 1'b0;
            res_d      = res_q;
        end
    end

    // Operand path is combinational so each accepted beat reaches the MAC in the same cycle
    assign a_ready   = (state_q == RUN);
    assign mac_en    = beat_c || (state_q == FLUSH);
    assign mac_act   = beat_c ? act_in : '0;
    assign mac_wgt   = beat_c ? wgt_in : '0;
    assign mac_prec  = prec_q;
    assign mac_rstn  = mac_rstn_q;
    assign res_valid = (state_q == DONE);
    assign res_data  = res_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

`ifdef MAC_SEQ_CTRL_PERF_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of RUN cycles without an operand
    always_comb begin
        stall_d = stall_q;
        if (state_q == CLEAR) begin
            stall_d = '0;
        end else if ((state_q == RUN) && !a_valid && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a lane-wise MAC unit model on mac_result.
// Define MAC_SEQ_CTRL_PERF_CNT_EN on both files to also check stall_cnt.
module tb_mac_seq_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  prec_in;
    logic [15:0] len;
    logic        abort;
    logic        a_valid;
    logic [7:0]  act_in;
    logic [7:0]  wgt_in;
    logic        a_ready;
    logic [7:0]  mac_act;
    logic [7:0]  mac_wgt;
    logic [1:0]  mac_prec;
    logic        mac_en;
    logic        mac_rstn;
    logic [55:0] mac_result;
    logic        res_valid;
    logic [55:0] res_data;
    logic        res_ready;
    logic        busy;
    logic        err;
`ifdef MAC_SEQ_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    mac_seq_ctrl #(.LEN_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .prec_in    (prec_in),
        .len        (len),
        .abort      (abort),
        .a_valid    (a_valid),
        .act_in     (act_in),
        .wgt_in     (wgt_in),
        .a_ready    (a_ready),
        .mac_act    (mac_act),
        .mac_wgt    (mac_wgt),
        .mac_prec   (mac_prec),
        .mac_en     (mac_en),
        .mac_rstn   (mac_rstn),
        .mac_result (mac_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
`ifdef MAC_SEQ_CTRL_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Lane-wise product: full 8x8, two 4-bit weight lanes of 28 bits, or four 2-bit lanes of 14 bits
    function automatic logic [55:0] lane_prod(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p);
        logic [55:0] r;
        r = '0;
        case (p)
            2'd0:    r = 56'(a) * 56'(w);
            2'd1:    for (int l = 0; l < 2; l++) r[l*28 +: 28] = 28'(a) * 28'(w[l*4 +: 4]);
            default: for (int l = 0; l < 4; l++) r[l*14 +: 14] = 14'(a) * 14'(w[l*2 +: 2]);
        endcase
        return r;
    endfunction

    // MAC unit model: cleared by mac_rstn AND rstn, accumulates on every mac_en cycle
    logic [55:0] acc;
    logic        mclr_n;
    assign mclr_n     = rstn & mac_rstn;
    assign mac_result = acc;
    always_ff @(posedge clk or negedge mclr_n) begin
        if (!mclr_n) acc <= '0;
        else if (mac_en) acc <= acc + lane_prod(mac_act, mac_wgt, mac_prec);
    end

    typedef struct {
        logic [55:0] data;
        int          c0;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         en_cnt = 0;
    logic [1:0] cur_prec = 2'd0;
    logic [7:0] act_a[16];
    logic [7:0] wgt_a[16];
    int         stall_a[16];

    task automatic chk(input string nm, input logic [63:0] actual, input logic [63:0] expect_v);
        checks++;
        if (actual !== expect_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, actual, expect_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops an expected result on each new res_valid, checks hold and MAC-port invariants
    task automatic monitor();
        logic prev_rv;
        exp_t cur;
        prev_rv  = 1'b0;
        cur.data = '0;
        cur.c0   = 0;
        cur.lat  = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_rv = 1'b0;
            end else begin
                if (mac_en) en_cnt++;
                else chk("mac_zero", 64'({mac_act, mac_wgt}), 64'd0);
                if (busy) chk("mac_prec", 64'(mac_prec), 64'(cur_prec));
                if (res_valid && !prev_rv) begin
                    if (sb.size() == 0) begin
                        chk("res_unexpected", 64'(res_valid), 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        chk("res_data", 64'(res_data), 64'(cur.data));
                        chk("latency", 64'(cyc - cur.c0), 64'(cur.lat));
                    end
                end else if (res_valid) begin
                    chk("res_hold", 64'(res_data), 64'(cur.data));
                end
                prev_rv = res_valid;
            end
        end
    endtask

    task automatic drive_noise(input logic noise);
        if (noise) begin
            start   = ($urandom % 3 == 0);
            prec_in = 2'($urandom);
            len     = 16'($urandom);
        end
    endtask

    // One job using act_a/wgt_a/stall_a; abort_at >= 0 aborts at that beat slot
    task automatic run_job(input logic [1:0] p, input int n, input int rdly, input int abort_at,
                           input logic abort_valid, input logic done_abort, input logic noise);
        exp_t        e;
        int          tot_st;
        logic [55:0] sum;
        sum    = '0;
        tot_st = 0;
        for (int i = 0; i < n; i++) begin
            sum    += lane_prod(act_a[i], wgt_a[i], p);
            tot_st += stall_a[i];
        end
        cur_prec = p;
        start    = 1'b1;
        prec_in  = p;
        len      = 16'(n);
        if (abort_at < 0) begin
            e.data = sum;
            e.c0   = cyc;
            e.lat  = n + 3 + tot_st;
            sb.push_back(e);
        end
        step();
        start = 1'b0;
        chk("busy_start", 64'(busy), 64'd1);
        chk("err_cleared", 64'(err), 64'd0);
        chk("clear_rstn", 64'(mac_rstn), 64'd0);
        step();
        if (n == 0) chk("no_ready_len0", 64'(a_ready), 64'd0);
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < stall_a[i]; s++) begin
                a_valid = 1'b0;
                drive_noise(noise);
                step();
            end
            chk("a_ready", 64'(a_ready), 64'd1);
            act_in = act_a[i];
            wgt_in = wgt_a[i];
            if (i == abort_at) begin
                a_valid = abort_valid;
                abort   = 1'b1;
                start   = 1'b0;
                step();
                abort   = 1'b0;
                a_valid = 1'b0;
                chk("abort_idle", 64'(busy), 64'd0);
                chk("abort_rstn_low", 64'(mac_rstn), 64'd0);
                step();
                chk("abort_rstn_high", 64'(mac_rstn), 64'd1);
                return;
            end
            a_valid = 1'b1;
            drive_noise(noise);
            step();
        end
        a_valid = 1'b0;
        start   = 1'b0;
        for (int t = 0; t < 20 && !res_valid; t++) step();
        chk("res_wait", 64'(res_valid), 64'd1);
        for (int d = 0; d < rdly; d++) begin
            abort = done_abort && (d == 0);
            step();
            abort = 1'b0;
            chk("done_hold", 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("done_exit", 64'(busy), 64'd0);
        chk("err_quiet", 64'(err), 64'd0);
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] w);
        for (int i = 0; i < 16; i++) begin
            act_a[i]   = a;
            wgt_a[i]   = w;
            stall_a[i] = 0;
        end
    endtask

    initial begin
        int base;
        rstn = 1'b0; start = 1'b0; prec_in = 2'd0; len = '0; abort = 1'b0;
        a_valid = 1'b0; act_in = '0; wgt_in = '0; res_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_mac_en", 64'(mac_en), 64'd0);
        chk("rst_mac_data", 64'({mac_act, mac_wgt}), 64'd0);
        chk("rst_mac_prec", 64'(mac_prec), 64'd0);
        chk("rst_mac_rstn", 64'(mac_rstn), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        step();
        rstn = 1'b1;
        step();
        chk("rstn_release", 64'(mac_rstn), 64'd1);

        fill(8'd2, 8'd3);
        run_job(2'd0, 3, 0, -1, 1'b0, 1'b0, 1'b0);
        fill(8'd5, 8'h55);
        run_job(2'd2, 2, 1, -1, 1'b0, 1'b0, 1'b0);
        run_job(2'd1, 0, 0, -1, 1'b0, 1'b0, 1'b0);

        start = 1'b1; prec_in = 2'b11; len = 16'd3;
        step();
        start = 1'b0;
        chk("illegal_err", 64'(err), 64'd1);
        chk("illegal_busy", 64'(busy), 64'd0);
        step();
        chk("illegal_stay", 64'(busy), 64'd0);
        fill(8'd7, 8'h9c);
        run_job(2'd1, 2, 0, -1, 1'b0, 1'b0, 1'b0);

        fill(8'd11, 8'd13);
        stall_a[1] = 2;
        stall_a[2] = 2;
        base = en_cnt;
        run_job(2'd0, 4, 0, -1, 1'b0, 1'b0, 1'b0);
        chk("mac_en_pulses", 64'(en_cnt - base), 64'd5);
`ifdef MAC_SEQ_CTRL_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd4);
`endif

        fill(8'd9, 8'd4);
        run_job(2'd0, 3, 0, 1, 1'b0, 1'b0, 1'b0);
        run_job(2'd0, 2, 3, -1, 1'b0, 1'b1, 1'b0);
        run_job(2'd2, 2, 0, 1, 1'b1, 1'b0, 1'b0);

        for (int j = 0; j < 40; j++) begin
            int n;
            int ab;
            n  = $urandom_range(0, 6);
            ab = -1;
            for (int i = 0; i < 16; i++) begin
                act_a[i]   = 8'($urandom);
                wgt_a[i]   = 8'($urandom);
                stall_a[i] = ($urandom % 3 == 0) ? $urandom_range(1, 2) : 0;
            end
            if (n > 0 && ($urandom % 6 == 0)) ab = $urandom_range(0, n - 1);
            run_job(2'($urandom_range(0, 2)), n, $urandom_range(0, 3), ab,
                    1'($urandom), 1'($urandom), 1'b1);
        end

        fill(8'd3, 8'd3);
        start = 1'b1; prec_in = 2'd0; len = 16'd4; cur_prec = 2'd0;
        step();
        start = 1'b0;
        step();
        a_valid = 1'b1;
        step();
        step();
        rstn = 1'b0;
        #1;
        a_valid = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_mac_rstn", 64'(mac_rstn), 64'd0);
        step();
        rstn = 1'b1;
        step();
        chk("midrst_idle", 64'(busy), 64'd0);
        run_job(2'd0, 3, 0, -1, 1'b0, 1'b0, 1'b0);

        repeat (3) step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter LEN_W, default 16, is the width of the vector-length operand.
REQ-002 Input clk, 1 bit, is the clock; all state changes occur on its rising edge.
REQ-003 Input rstn, 1 bit, is the reset: asynchronous, active-low.
REQ-004 Input start, 1 bit, requests a dot-product job; it is sampled only in IDLE.
REQ-005 Input prec_in, 2 bits, is the precision level: 00 full, 01 4-bit weight, 10 2-bit weight, 11 illegal.
REQ-006 Input len, LEN_W bits, is the number of activation/weight pairs in the job.
REQ-007 Input abort, 1 bit, requests job cancellation.
REQ-008 Inputs a_valid (1 bit), act_in (8 bits) and wgt_in (8 bits) form the operand stream.
REQ-009 Output a_ready, 1 bit, is the operand-stream ready.
REQ-010 Outputs mac_act (8 bits), mac_wgt (8 bits), mac_prec (2 bits) and mac_en (1 bit) drive the MAC unit.
REQ-011 Output mac_rstn, 1 bit, is the registered active-low MAC clear; the integration ANDs it with rstn.
REQ-012 Input mac_result, 56 bits, is the MAC accumulator.
REQ-013 Outputs res_valid (1 bit) and res_data (56 bits), with input res_ready (1 bit), form the result handshake.
REQ-014 Outputs busy (1 bit) and err (1 bit) are job status.

Function
REQ-015 The FSM shall have the states IDLE, CLEAR, RUN, FLUSH and DONE.
REQ-016 IDLE transitions:
- start=1 and prec_in!=11: latch prec_in and len, go to CLEAR.
- start=1 and prec_in=11: set err=1 and stay in IDLE.
- err shall be cleared by the next legal start.
REQ-017 CLEAR shall last exactly 1 cycle with mac_rstn=0 and mac_en=0.
- Go to FLUSH if the latched len=0, else go to RUN.
REQ-018 In RUN, a_ready=1; each beat with a_valid&a_ready shall:
- drive mac_en=1;
- pass act_in/wgt_in combinationally to mac_act/mac_wgt;
- decrement the remaining count.
REQ-019 In RUN with a_valid=0, mac_en=0 and the MAC state holds (stall).
REQ-020 After the beat that takes the remaining count to 0, the FSM shall go to FLUSH.
REQ-021 FLUSH shall last exactly 1 cycle with mac_en=1, mac_act=0 and mac_wgt=0, so the final product registered in the MAC is added to the accumulator.
REQ-022 On the FLUSH-to-DONE transition, mac_result shall be captured into res_data; in DONE, res_valid=1.
REQ-023 DONE shall hold res_data and res_valid until res_ready=1, then go to IDLE.
REQ-024 mac_prec shall equal the latched precision for the whole job, including FLUSH.
REQ-025 busy=1 in every state except IDLE.
REQ-026 A start asserted while busy=1 shall be ignored.
REQ-027 abort=1 in CLEAR, RUN or FLUSH shall go to IDLE next cycle:
- no res_valid is produced;
- mac_rstn is pulsed low for 1 cycle.
REQ-028 abort in DONE shall be ignored.
REQ-029 If abort and the last operand beat coincide, abort shall win.
REQ-030 Job latency with no stalls and len=N≥1 shall be N+3 cycles from start to res_valid.
REQ-031 mac_act/mac_wgt shall be 0 whenever mac_en=0.

Reset
REQ-032 While rstn=0 the block shall be in IDLE with these outputs:
- busy=0, err=0, a_ready=0;
- mac_en=0, mac_act=0, mac_wgt=0, mac_prec=00;
- mac_rstn=0;
- res_valid=0, res_data=0.
REQ-033 mac_rstn shall be 1 from the first clock edge after reset release.
REQ-034 A reset mid-job shall discard the job with no result.

Configuration
REQ-035 With macro MAC_SEQ_CTRL_PERF_CNT_EN defined:
- output stall_cnt (16 bits) counts RUN cycles with a_valid=0;
- it saturates at 0xFFFF and clears on CLEAR.
REQ-036 Without MAC_SEQ_CTRL_PERF_CNT_EN, stall_cnt and its counter shall not exist.

Verification
REQ-037 prec 00, len=3, act=2, wgt=3 each beat, no stalls -> res_valid at cycle 6 after start, res_data=18.
REQ-038 prec 10, len=2, act=5, wgt=8'h55 -> res_data={14'd10,14'd10,14'd10,14'd10}.
REQ-039 len=0, prec 01 -> CLEAR, FLUSH, DONE with res_data=0 and no a_ready beat accepted.
REQ-040 prec 11 start -> err=1, busy stays 0; then a legal start -> err=0.
REQ-041 len=4 with a_valid low on beats 2-3 for 2 cycles each -> mac_en pulses exactly 5 times (4 beats + flush); stall_cnt=4 if enabled.
REQ-042 abort in RUN after 1 beat -> IDLE next cycle, mac_rstn low 1 cycle, no res_valid; res_ready held low in DONE holds res_data stable.
